// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load write-back, plus a RAW pending scoreboard.
// Optional forwarding outputs are enabled by defining REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req_Valid0,
    input  logic [ADDR_W-1:0] Req_Reg0,
    input  logic [DATA_W-1:0] Req_Data0,
    output logic              Req_Ready0,
    input  logic              Req_Valid1,
    input  logic [ADDR_W-1:0] Req_Reg1,
    input  logic [DATA_W-1:0] Req_Data1,
    output logic              Req_Ready1,
    input  logic              Issue_Valid,
    input  logic [ADDR_W-1:0] Issue_Reg,
    input  logic [ADDR_W-1:0] Read_Register1,
    input  logic [ADDR_W-1:0] Read_Register2,
    output logic              Busy1,
    output logic              Busy2,
`ifdef REGFILE_WB_BYPASS_EN
    output logic              Fwd_Hit1,
    output logic              Fwd_Hit2,
    output logic [DATA_W-1:0] Fwd_Data1,
    output logic [DATA_W-1:0] Fwd_Data2,
`endif
    output logic              Reg_Write,
    output logic [ADDR_W-1:0] Write_Register,
    output logic [DATA_W-1:0] Write_Data,
    output logic [CNT_W-1:0]  Wb_Count
);

    localparam int NREG = 2 ** ADDR_W;

    logic              last_grant;
    logic              grant0;
    logic              grant1;
    logic              any_grant;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_next;
    logic              sb_busy1;
    logic              sb_busy2;

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!Reset) begin
            if (Req_Valid0 && Req_Valid1) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = Req_Valid0;
                grant1 = Req_Valid1;
            end
        end
    end

    assign Req_Ready0 = grant0;
    assign Req_Ready1 = grant1;
    assign any_grant  = grant0 | grant1;
    assign sel_reg    = grant1 ? Req_Reg1  : Req_Reg0;
    assign sel_data   = grant1 ? Req_Data1 : Req_Data0;

    // A commit clears its bit, but a same-edge issue to that register is a newer producer and wins.
    always_comb begin
        pending_next = pending;
        if (Reg_Write) begin
            pending_next[Write_Register] = 1'b0;
        end
        if (Issue_Valid && (Issue_Reg != '0)) begin
            pending_next[Issue_Reg] = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Reg_Write      <= 1'b0;
            Write_Register <= '0;
            Write_Data     <= '0;
            Wb_Count       <= '0;
            last_grant     <= 1'b1;
            pending        <= '0;
        end else begin
            if (any_grant) begin
                last_grant <= grant1;
            end
            Reg_Write <= any_grant && (sel_reg != '0);
            // Writes to $0 are consumed but never reach the register file.
            if (any_grant && (sel_reg != '0)) begin
                Write_Register <= sel_reg;
                Write_Data     <= sel_data;
            end
            if (Reg_Write) begin
                Wb_Count <= Wb_Count + CNT_W'(1);
            end
            pending <= pending_next;
        end
    end

    assign sb_busy1 = pending[Read_Register1] && (Read_Register1 != '0);
    assign sb_busy2 = pending[Read_Register2] && (Read_Register2 != '0);

`ifdef REGFILE_WB_BYPASS_EN
    // The value being written this cycle is forwarded, so decode need not stall on it.
    assign Fwd_Hit1  = Reg_Write && (Write_Register == Read_Register1) && (Read_Register1 != '0);
    assign Fwd_Hit2  = Reg_Write && (Write_Register == Read_Register2) && (Read_Register2 != '0);
    assign Fwd_Data1 = Fwd_Hit1 ? Write_Data : '0;
    assign Fwd_Data2 = Fwd_Hit2 ? Write_Data : '0;
    assign Busy1     = sb_busy1 && !Fwd_Hit1;
    assign Busy2     = sb_busy2 && !Fwd_Hit2;
`else
    assign Busy1     = sb_busy1;
    assign Busy2     = sb_busy2;
`endif

endmodule
